// File: rtl/adc_scan_sequencer.sv
// adc_scan_sequencer
// Autonomous ADC scan scheduler. A free-running period counter produces a
// one-cycle tick; each tick starts a scan over the channels set in cfg_mask.
// For every channel the sequencer drives CH_SEL, waits SETTLE cycles, pulses
// SOC, follows the BUSY high/low handshake with a per-phase timeout, and
// stores DATA into a per-channel result register with a "fresh" flag that
// the register interface clears by acknowledging the read.
module adc_scan_sequencer #(
  parameter int NCH    = 4,
  parameter int DW     = 10,
  parameter int PW     = 16,
  parameter int SETTLE = 2,
  parameter int TMO    = 255,
  localparam int CW    = $clog2(NCH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          cfg_en,
  input  logic [NCH-1:0] cfg_mask,
  input  logic [PW-1:0] cfg_period,
  input  logic          err_clr,
  output logic [CW-1:0] CH_SEL,
  output logic          SOC,
  input  logic          BUSY,
  input  logic [DW-1:0] DATA,
  input  logic [CW-1:0] rd_ch,
  input  logic          rd_ack,
  output logic [DW-1:0] rd_data,
  output logic          rd_fresh,
  output logic          scan_active,
  output logic          scan_done,
  output logic          ovr_err,
  output logic          tmo_err
);

  localparam int SW = $clog2(SETTLE + 1);
  localparam int TW = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO,
    S_NEXT
  } state_t;

  state_t         state_q, state_d;
  logic [PW-1:0]  cnt_q, cnt_d;
  logic           tick_q, tick_d;
  logic           tick;
  logic [NCH-1:0] scan_mask_q, scan_mask_d;
  logic [CW-1:0]  ch_q, ch_d;
  logic [SW-1:0]  sel_cnt_q, sel_cnt_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [DW-1:0]  result_q [NCH];
  logic [DW-1:0]  result_d [NCH];
  logic [NCH-1:0] fresh_q, fresh_d;
  logic           ovr_q, ovr_d;
  logic           tmo_q, tmo_d;

  logic [CW-1:0]  first_ch;
  logic [CW-1:0]  nxt_ch;
  logic           nxt_found;
  logic           capture;
  logic           tmo_hit;
  logic           done;
  logic           rd_in_range;

  // Period counter: wraps every cfg_period+1 cycles while enabled. The tick
  // is registered, so the first one lands cfg_period+1 cycles after enable.
  // A tick left in the register when cfg_en drops is masked off.
  always_comb begin
    cnt_d  = '0;
    tick_d = 1'b0;
    if (cfg_en) begin
      tick_d = (cnt_q == cfg_period);
      cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick = tick_q & cfg_en;

  // Channel search: lowest set bit of cfg_mask to open a scan, and the
  // lowest set bit of the latched scan mask strictly above the current one.
  always_comb begin
    first_ch  = '0;
    nxt_ch    = '0;
    nxt_found = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (cfg_mask[i]) begin
        first_ch = CW'(i);
      end
      if (scan_mask_q[i] && (i > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CW'(i);
      end
    end
  end

  // Scan FSM next-state logic: settle, SOC, BUSY handshake with timeout,
  // then step to the next masked channel or finish the scan.
  always_comb begin
    state_d     = state_q;
    scan_mask_d = scan_mask_q;
    ch_d        = ch_q;
    sel_cnt_d   = sel_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    capture     = 1'b0;
    tmo_hit     = 1'b0;
    done        = 1'b0;
    case (state_q)
      S_IDLE: begin
        // An empty mask makes the tick a no-op rather than an error.
        if (tick && (|cfg_mask)) begin
          scan_mask_d = cfg_mask;
          ch_d        = first_ch;
          sel_cnt_d   = '0;
          state_d     = S_SELECT;
        end
      end
      S_SELECT: begin
        if (sel_cnt_q == SW'(SETTLE - 1)) begin
          state_d = S_START;
        end else begin
          sel_cnt_d = sel_cnt_q + 1'b1;
        end
      end
      S_START: begin
        tmo_cnt_d = '0;
        state_d   = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (BUSY) begin
          tmo_cnt_d = '0;
          state_d   = S_WAIT_LO;
        end else if (tmo_cnt_q == TW'(TMO - 1)) begin
          tmo_hit = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_WAIT_LO: begin
        if (!BUSY) begin
          capture = 1'b1;
          state_d = S_NEXT;
        end else if (tmo_cnt_q == TW'(TMO - 1)) begin
          tmo_hit = 1'b1;
          state_d = S_NEXT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_NEXT: begin
        // Dropping cfg_en lets the current conversion finish but starts no
        // further channel.
        if (nxt_found && cfg_en) begin
          ch_d      = nxt_ch;
          sel_cnt_d = '0;
          state_d   = S_SELECT;
        end else begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign rd_in_range = (int'(rd_ch) < NCH);

  // Result store and fresh flags: an acknowledge clears, a capture on the
  // same channel in the same cycle overrides it.
  always_comb begin
    result_d = result_q;
    fresh_d  = fresh_q;
    if (rd_ack && rd_in_range) begin
      fresh_d[rd_ch] = 1'b0;
    end
    if (capture) begin
      result_d[ch_q] = DATA;
      fresh_d[ch_q]  = 1'b1;
    end
  end

  // Sticky error flags: clear first, so a same-cycle new error still sets.
  always_comb begin
    ovr_d = ovr_q;
    tmo_d = tmo_q;
    if (err_clr) begin
      ovr_d = 1'b0;
      tmo_d = 1'b0;
    end
    if (tick && (state_q != S_IDLE)) begin
      ovr_d = 1'b1;
    end
    if (tmo_hit) begin
      tmo_d = 1'b1;
    end
  end

  // State registers, all cleared asynchronously so a reset mid-conversion
  // abandons the handshake immediately.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      tick_q      <= 1'b0;
      scan_mask_q <= '0;
      ch_q        <= '0;
      sel_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      result_q    <= '{default: '0};
      fresh_q     <= '0;
      ovr_q       <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      scan_mask_q <= scan_mask_d;
      ch_q        <= ch_d;
      sel_cnt_q   <= sel_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      result_q    <= result_d;
      fresh_q     <= fresh_d;
      ovr_q       <= ovr_d;
      tmo_q       <= tmo_d;
    end
  end

  assign CH_SEL      = ch_q;
  assign SOC         = (state_q == S_START);
  assign scan_active = (state_q != S_IDLE);
  assign scan_done   = done;
  assign ovr_err     = ovr_q;
  assign tmo_err     = tmo_q;
  assign rd_data     = rd_in_range ? result_q[rd_ch] : '0;
  assign rd_fresh    = rd_in_range ? fresh_q[rd_ch] : 1'b0;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb_adc_scan_sequencer
// Directed bench for adc_scan_sequencer with a behavioural ADC: BUSY rises
// two cycles after SOC, stays high adc_len cycles, and DATA comes from a
// per-channel table. Channels flagged in adc_stuck never raise BUSY.
module tb_adc_scan_sequencer;

  localparam int NCH = 4;
  localparam int DW  = 10;
  localparam int PW  = 16;
  localparam int CW  = 2;

  logic           clk        = 1'b0;
  logic           rst        = 1'b1;
  logic           cfg_en     = 1'b0;
  logic [NCH-1:0] cfg_mask   = '0;
  logic [PW-1:0]  cfg_period = '0;
  logic           err_clr    = 1'b0;
  logic [CW-1:0]  ch_sel;
  logic           soc;
  logic           busy       = 1'b0;
  logic [DW-1:0]  data       = '0;
  logic [CW-1:0]  rd_ch      = '0;
  logic           rd_ack     = 1'b0;
  logic [DW-1:0]  rd_data;
  logic           rd_fresh;
  logic           scan_active;
  logic           scan_done;
  logic           ovr_err;
  logic           tmo_err;

  int n_tests = 0;
  int n_fail  = 0;

  adc_scan_sequencer #(
    .NCH(NCH), .DW(DW), .PW(PW), .SETTLE(2), .TMO(255)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .cfg_en     (cfg_en),
    .cfg_mask   (cfg_mask),
    .cfg_period (cfg_period),
    .err_clr    (err_clr),
    .CH_SEL     (ch_sel),
    .SOC        (soc),
    .BUSY       (busy),
    .DATA       (data),
    .rd_ch      (rd_ch),
    .rd_ack     (rd_ack),
    .rd_data    (rd_data),
    .rd_fresh   (rd_fresh),
    .scan_active(scan_active),
    .scan_done  (scan_done),
    .ovr_err    (ovr_err),
    .tmo_err    (tmo_err)
  );

  always #5 clk = ~clk;

  // ADC model
  logic [DW-1:0]  data_tab [NCH];
  int             adc_len   = 12;
  logic [NCH-1:0] adc_stuck = '0;
  bit             adc_run   = 1'b0;
  int             adc_t     = 0;
  logic [CW-1:0]  adc_ch    = '0;

  always @(negedge clk) begin
    if (adc_run) begin
      adc_t++;
      if (adc_t == 2) begin
        busy = 1'b1;
        data = data_tab[adc_ch];
      end
      if (adc_t == 2 + adc_len) begin
        busy    = 1'b0;
        adc_run = 1'b0;
      end
    end else if (soc && !adc_stuck[ch_sel]) begin
      adc_run = 1'b1;
      adc_t   = 0;
      adc_ch  = ch_sel;
    end
  end

  // Event monitor
  int            soc_cnt  = 0;
  int            done_cnt = 0;
  int            act_cnt  = 0;
  logic [CW-1:0] soc_ch [1024];

  always @(negedge clk) begin
    if (soc) begin
      if (soc_cnt < 1024) soc_ch[soc_cnt] = ch_sel;
      soc_cnt++;
    end
    if (scan_done) done_cnt++;
    if (scan_active) act_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_soc(input int bound, input bit any_ch, input logic [CW-1:0] ch,
                          output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (soc && (any_ch || ch_sel == ch)) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (scan_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step(3);
    n_tests++; if (soc !== 1'b0) begin n_fail++; $display("FAIL reset_soc: got %b expected 0", soc); end
    n_tests++; if (scan_active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", scan_active); end
    n_tests++; if (scan_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", scan_done); end
    n_tests++; if (ch_sel !== 2'd0) begin n_fail++; $display("FAIL reset_ch_sel: got %0d expected 0", ch_sel); end
    n_tests++; if (ovr_err !== 1'b0 || tmo_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got ovr=%b tmo=%b expected 0 0", ovr_err, tmo_err); end
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CW'(c);
      #1;
      n_tests++;
      if (rd_data !== '0 || rd_fresh !== 1'b0) begin
        n_fail++; $display("FAIL reset_result ch%0d: got data=%0h fresh=%b expected 0 0", c, rd_data, rd_fresh);
      end
    end
    rst = 1'b0;
    step(2);
  endtask

  task automatic test_empty_mask;
    int b_soc, b_act;
    b_soc = soc_cnt; b_act = act_cnt;
    cfg_mask = '0; cfg_period = 16'd4; cfg_en = 1'b1;
    step(50);
    cfg_en = 1'b0;
    step(2);
    n_tests++; if (soc_cnt - b_soc != 0) begin n_fail++; $display("FAIL empty_soc: got %0d pulses expected 0", soc_cnt - b_soc); end
    n_tests++; if (act_cnt - b_act != 0) begin n_fail++; $display("FAIL empty_active: got %0d active cycles expected 0", act_cnt - b_act); end
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL empty_ovr: got %b expected 0", ovr_err); end
  endtask

  task automatic test_basic_scan;
    int b_soc, b_done;
    bit ok;
    logic [DW-1:0] exp_d [NCH];
    logic          exp_f [NCH];
    exp_d[0] = 10'h155; exp_d[1] = 10'h000; exp_d[2] = 10'h2AA; exp_d[3] = 10'h000;
    exp_f[0] = 1'b1;    exp_f[1] = 1'b0;    exp_f[2] = 1'b1;    exp_f[3] = 1'b0;
    data_tab[0] = 10'h155; data_tab[2] = 10'h2AA; adc_len = 12;
    step(1);
    b_soc = soc_cnt; b_done = done_cnt;
    cfg_mask = 4'b0101; cfg_period = 16'd99; cfg_en = 1'b1;
    // tick occupies cycle 100, scan_active from 101, SOC in 103
    step(100);
    n_tests++; if (scan_active !== 1'b0) begin n_fail++; $display("FAIL basic_active_tick: got %b expected 0", scan_active); end
    step(1);
    n_tests++; if (scan_active !== 1'b1 || soc !== 1'b0) begin n_fail++; $display("FAIL basic_active_start: got act=%b soc=%b expected 1 0", scan_active, soc); end
    step(1);
    n_tests++; if (soc !== 1'b0) begin n_fail++; $display("FAIL basic_soc_early: got %b expected 0", soc); end
    step(1);
    n_tests++; if (soc !== 1'b1 || ch_sel !== 2'd0) begin n_fail++; $display("FAIL basic_soc_latency: got soc=%b ch=%0d expected 1 0", soc, ch_sel); end
    wait_done(200, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got no scan_done expected one within 200 cycles"); end
    cfg_en = 1'b0;
    step(1);
    n_tests++; if (soc_cnt - b_soc != 2) begin n_fail++; $display("FAIL basic_soc_count: got %0d expected 2", soc_cnt - b_soc); end
    n_tests++; if (soc_ch[b_soc] !== 2'd0 || soc_ch[b_soc+1] !== 2'd2) begin n_fail++; $display("FAIL basic_ch_order: got %0d,%0d expected 0,2", soc_ch[b_soc], soc_ch[b_soc+1]); end
    n_tests++; if (done_cnt - b_done != 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", done_cnt - b_done); end
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CW'(c);
      #1;
      n_tests++;
      if (rd_data !== exp_d[c] || rd_fresh !== exp_f[c]) begin
        n_fail++; $display("FAIL basic_result ch%0d: got data=%0h fresh=%b expected %0h %b", c, rd_data, rd_fresh, exp_d[c], exp_f[c]);
      end
    end
    step(2);
  endtask

  task automatic test_read_ack;
    rd_ch = 2'd2;
    #1;
    n_tests++; if (rd_data !== 10'h2AA || rd_fresh !== 1'b1) begin n_fail++; $display("FAIL ack_before: got data=%0h fresh=%b expected 2aa 1", rd_data, rd_fresh); end
    rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    n_tests++; if (rd_fresh !== 1'b0 || rd_data !== 10'h2AA) begin n_fail++; $display("FAIL ack_clear: got data=%0h fresh=%b expected 2aa 0", rd_data, rd_fresh); end
    rd_ch = 2'd0;
    #1;
    n_tests++; if (rd_fresh !== 1'b1) begin n_fail++; $display("FAIL ack_other_ch: got %b expected 1", rd_fresh); end
    step(1);
  endtask

  task automatic test_ack_capture;
    bit ok;
    data_tab[0] = 10'h0F0; adc_len = 12;
    cfg_mask = 4'b0001; cfg_period = 16'd49; cfg_en = 1'b1;
    wait_soc(100, 1'b1, 2'd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL ackcap_soc_timeout: got no SOC expected one within 100 cycles"); end
    // BUSY falls in cycle SOC+14; the DUT captures at the end of that cycle
    step(14);
    rd_ch = 2'd0; rd_ack = 1'b1;
    step(1);
    rd_ack = 1'b0;
    n_tests++; if (rd_fresh !== 1'b1 || rd_data !== 10'h0F0) begin n_fail++; $display("FAIL ackcap_set_wins: got data=%0h fresh=%b expected 0f0 1", rd_data, rd_fresh); end
    n_tests++; if (scan_done !== 1'b1) begin n_fail++; $display("FAIL ackcap_done: got %b expected 1", scan_done); end
    cfg_en = 1'b0;
    step(2);
  endtask

  task automatic test_overrun;
    int b_soc, b_done, dones;
    bit ovr_seen;
    data_tab[0] = 10'h101; data_tab[1] = 10'h102; data_tab[2] = 10'h103; data_tab[3] = 10'h104;
    adc_len = 20;
    b_soc = soc_cnt; b_done = done_cnt; dones = 0; ovr_seen = 1'b0;
    err_clr = 1'b1;
    cfg_mask = 4'b1111; cfg_period = 16'd9; cfg_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step(1);
      if (ovr_err) ovr_seen = 1'b1;
      if (scan_done) begin
        dones++;
        if (dones == 1) err_clr = 1'b0;
        if (dones == 2) break;
      end
    end
    cfg_en = 1'b0;
    err_clr = 1'b0;
    step(1);
    n_tests++; if (dones != 2) begin n_fail++; $display("FAIL ovr_scans: got %0d scans expected 2 within 600 cycles", dones); end
    n_tests++; if (ovr_seen !== 1'b1) begin n_fail++; $display("FAIL ovr_set_beats_clr: got %b expected 1", ovr_seen); end
    n_tests++; if (ovr_err !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", ovr_err); end
    n_tests++; if (soc_cnt - b_soc != 8) begin n_fail++; $display("FAIL ovr_soc_count: got %0d expected 8", soc_cnt - b_soc); end
    n_tests++; if (done_cnt - b_done != 2) begin n_fail++; $display("FAIL ovr_done_count: got %0d expected 2", done_cnt - b_done); end
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if (soc_ch[b_soc+k] !== CW'(k % 4)) begin
        n_fail++; $display("FAIL ovr_ch_order soc%0d: got %0d expected %0d", k, soc_ch[b_soc+k], k % 4);
      end
    end
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    n_tests++; if (ovr_err !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", ovr_err); end
    n_tests++; if (tmo_err !== 1'b0) begin n_fail++; $display("FAIL ovr_no_tmo: got %b expected 0", tmo_err); end
    for (int c = 0; c < NCH; c++) begin
      rd_ch = CW'(c); rd_ack = 1'b1;
      step(1);
    end
    rd_ack = 1'b0;
    step(1);
  endtask

  task automatic test_timeout;
    int b_soc;
    bit ok;
    data_tab[0] = 10'h0AB; adc_len = 12; adc_stuck = 4'b0010;
    b_soc = soc_cnt;
    cfg_mask = 4'b0011; cfg_period = 16'd399; cfg_en = 1'b1;
    wait_soc(500, 1'b0, 2'd1, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL tmo_soc_timeout: got no SOC on ch1 expected one within 500 cycles"); end
    // WAIT_HI spans SOC+1 .. SOC+255; timeout lands in SOC+256
    step(255);
    n_tests++; if (tmo_err !== 1'b0 || scan_done !== 1'b0) begin n_fail++; $display("FAIL tmo_early: got tmo=%b done=%b expected 0 0", tmo_err, scan_done); end
    step(1);
    n_tests++; if (tmo_err !== 1'b1 || scan_done !== 1'b1) begin n_fail++; $display("FAIL tmo_fire: got tmo=%b done=%b expected 1 1", tmo_err, scan_done); end
    cfg_en = 1'b0; adc_stuck = '0;
    step(1);
    n_tests++; if (soc_cnt - b_soc != 2) begin n_fail++; $display("FAIL tmo_soc_count: got %0d expected 2", soc_cnt - b_soc); end
    rd_ch = 2'd1;
    #1;
    n_tests++; if (rd_data !== 10'h102 || rd_fresh !== 1'b0) begin n_fail++; $display("FAIL tmo_ch1_kept: got data=%0h fresh=%b expected 102 0", rd_data, rd_fresh); end
    rd_ch = 2'd0;
    #1;
    n_tests++; if (rd_data !== 10'h0AB || rd_fresh !== 1'b1) begin n_fail++; $display("FAIL tmo_ch0_conv: got data=%0h fresh=%b expected 0ab 1", rd_data, rd_fresh); end
    step(2);
  endtask

  task automatic test_stop;
    int b_soc, b_done;
    bit ok;
    data_tab[0] = 10'h1C3; adc_len = 12;
    b_soc = soc_cnt; b_done = done_cnt;
    cfg_mask = 4'b1111; cfg_period = 16'd49; cfg_en = 1'b1;
    wait_soc(100, 1'b1, 2'd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_soc_timeout: got no SOC expected one within 100 cycles"); end
    step(5);
    cfg_en = 1'b0;
    wait_done(30, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL stop_done_timeout: got no scan_done expected one within 30 cycles"); end
    step(5);
    n_tests++; if (soc_cnt - b_soc != 1) begin n_fail++; $display("FAIL stop_soc_count: got %0d expected 1", soc_cnt - b_soc); end
    n_tests++; if (done_cnt - b_done != 1) begin n_fail++; $display("FAIL stop_done_count: got %0d expected 1", done_cnt - b_done); end
    n_tests++; if (scan_active !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got %b expected 0", scan_active); end
    rd_ch = 2'd0;
    #1;
    n_tests++; if (rd_data !== 10'h1C3 || rd_fresh !== 1'b1) begin n_fail++; $display("FAIL stop_ch0_stored: got data=%0h fresh=%b expected 1c3 1", rd_data, rd_fresh); end
  endtask

  task automatic test_reset_midconv;
    int b_done;
    bit ok;
    data_tab[0] = 10'h3FF; adc_len = 12;
    rd_ch = 2'd0;
    cfg_mask = 4'b0001; cfg_period = 16'd49; cfg_en = 1'b1;
    wait_soc(100, 1'b1, 2'd0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL rstmid_soc_timeout: got no SOC expected one within 100 cycles"); end
    step(5);
    n_tests++; if (tmo_err !== 1'b1 || scan_active !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre: got tmo=%b act=%b expected 1 1", tmo_err, scan_active); end
    #2;
    rst = 1'b1; cfg_en = 1'b0;
    #1;
    n_tests++; if (scan_active !== 1'b0 || soc !== 1'b0 || scan_done !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: got act=%b soc=%b done=%b expected 0 0 0", scan_active, soc, scan_done); end
    n_tests++; if (ch_sel !== 2'd0 || tmo_err !== 1'b0 || ovr_err !== 1'b0) begin n_fail++; $display("FAIL rstmid_outs: got ch=%0d tmo=%b ovr=%b expected 0 0 0", ch_sel, tmo_err, ovr_err); end
    n_tests++; if (rd_data !== '0 || rd_fresh !== 1'b0) begin n_fail++; $display("FAIL rstmid_result: got data=%0h fresh=%b expected 0 0", rd_data, rd_fresh); end
    step(2);
    rst = 1'b0;
    b_done = done_cnt;
    step(20);
    n_tests++; if (scan_active !== 1'b0 || done_cnt != b_done) begin n_fail++; $display("FAIL rstmid_idle: got act=%b dones=%0d expected 0 0", scan_active, done_cnt - b_done); end
    n_tests++; if (rd_data !== '0 || rd_fresh !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_capture: got data=%0h fresh=%b expected 0 0", rd_data, rd_fresh); end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) data_tab[c] = '0;
    test_reset();
    test_empty_mask();
    test_basic_scan();
    test_read_ack();
    test_ack_capture();
    test_overrun();
    test_timeout();
    test_stop();
    test_reset_midconv();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no completion expected finish before 1000000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
